// File: rtl/gpio_ctrl_if.sv
// ---------------------------------------------------------------------------
// gpio_ctrl_if : request/response bus between the core and the GPIO block.
//   req_valid/req_ready : request handshake (master -> slave)
//   req_we, req_addr, req_wdata : write enable, word address, write data
//   rsp_valid/rsp_ready : response handshake (slave -> master)
//   rsp_rdata : read data, zero for write acknowledges
// ---------------------------------------------------------------------------
interface gpio_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/gpio_ctrl.sv
// ---------------------------------------------------------------------------
// gpio_ctrl : memory-mapped GPIO controller.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : gpio_ctrl_if.slave request/response port
//   gpio_in    : raw asynchronous pin levels
//   gpio_out   : pin drive values (DATA_OUT register)
//   gpio_oe    : pin output enables, 1 = drive (DIR register)
//   irq        : registered OR of pending, enabled edge events
// Register map (word address): 0 DATA_OUT, 1 DIR, 2 DATA_IN, 3 SET, 4 CLR,
// 5 TGL, 6 IRQ_RISE, 7 IRQ_FALL, 8 IRQ_STATUS (write-1-to-clear).
// ---------------------------------------------------------------------------
module gpio_ctrl #(
    parameter int          WIDTH     = 8,
    parameter logic [31:0] OUT_RESET = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    gpio_ctrl_if.slave        bus,
    input  logic [WIDTH-1:0]  gpio_in,
    output logic [WIDTH-1:0]  gpio_out,
    output logic [WIDTH-1:0]  gpio_oe,
    output logic              irq
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] OUT_RST = OUT_RESET[WIDTH-1:0];

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q,  out_d;
    logic [WIDTH-1:0] dir_q,  dir_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] stat_q, stat_d;
    logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
    logic [31:0]      rdata_q, rdata_d;
    logic             irq_q,   irq_d;

    logic             accept_s;
    logic [WIDTH-1:0] wdata_s;
    logic [WIDTH-1:0] w1c_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic [31:0]      rd_s;
    logic             unused_wdata_s;

    // Zero-extend a pin-wide value to the 32-bit bus.
    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r = 32'h0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    assign accept_s       = (state_q == ST_IDLE) && bus.req_valid;
    assign wdata_s        = bus.req_wdata[WIDTH-1:0];
    assign unused_wdata_s = ^bus.req_wdata;

    // Edges are judged on synchronised levels only; DIR plays no part so driven pins loop back.
    assign rise_s = sync2_q & ~prev_q & rise_q;
    assign fall_s = ~sync2_q & prev_q & fall_q;

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign gpio_out      = out_q;
    assign gpio_oe       = dir_q;
    assign irq           = irq_q;

    // Handshake FSM next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) state_d = ST_RESP;
                else               state_d = ST_IDLE;
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
                else               state_d = ST_RESP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read mux over pre-update register state.
    always_comb begin
        rd_s = 32'h0;
        case (bus.req_addr)
            4'd0:    rd_s = zext(out_q);
            4'd1:    rd_s = zext(dir_q);
            4'd2:    rd_s = zext(sync2_q);
            4'd6:    rd_s = zext(rise_q);
            4'd7:    rd_s = zext(fall_q);
            4'd8:    rd_s = zext(stat_q);
            default: rd_s = 32'h0;
        endcase
    end

    // Register write decode, response capture, status and irq next-state.
    always_comb begin
        out_d   = out_q;
        dir_d   = dir_q;
        rise_d  = rise_q;
        fall_d  = fall_q;
        w1c_s   = {WIDTH{1'b0}};
        rdata_d = rdata_q;
        if (accept_s) begin
            if (bus.req_we) rdata_d = 32'h0;
            else            rdata_d = rd_s;
        end else begin
            rdata_d = rdata_q;
        end
        if (accept_s && bus.req_we) begin
            case (bus.req_addr)
                4'd0:    out_d  = wdata_s;
                4'd1:    dir_d  = wdata_s;
                4'd3:    out_d  = out_q | wdata_s;
                4'd4:    out_d  = out_q & ~wdata_s;
                4'd5:    out_d  = out_q ^ wdata_s;
                4'd6:    rise_d = wdata_s;
                4'd7:    fall_d = wdata_s;
                4'd8:    w1c_s  = wdata_s;
                default: out_d  = out_q;
            endcase
        end else begin
            out_d = out_q;
        end
        // New edges are OR-ed in after the clear, so a coinciding edge keeps its bit set.
        stat_d = (stat_q & ~w1c_s) | rise_s | fall_s;
        irq_d  = |(stat_q & (rise_q | fall_q));
    end

    // State, register file, synchroniser and irq flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            out_q   <= OUT_RST;
            dir_q   <= {WIDTH{1'b0}};
            rise_q  <= {WIDTH{1'b0}};
            fall_q  <= {WIDTH{1'b0}};
            stat_q  <= {WIDTH{1'b0}};
            sync1_q <= {WIDTH{1'b0}};
            sync2_q <= {WIDTH{1'b0}};
            prev_q  <= {WIDTH{1'b0}};
            rdata_q <= 32'h0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            dir_q   <= dir_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            stat_q  <= stat_d;
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

endmodule

// File: tb/tb_gpio_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gpio_ctrl : self-checking bench for gpio_ctrl (WIDTH=8, OUT_RESET=0x5A).
// Expected values come from the register-map rules applied to a small set of
// bench-side shadow variables (pin values, output/direction registers).
// ---------------------------------------------------------------------------
module tb_gpio_ctrl;
    localparam int          W       = 8;
    localparam logic [31:0] OUT_RST = 32'h0000_005A;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] gpio_in;
    logic [W-1:0] gpio_out;
    logic [W-1:0] gpio_oe;
    logic         irq;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  m_out;
    logic [7:0]  m_dir;
    logic [7:0]  m_pin;
    logic [31:0] rd;

    gpio_ctrl_if bus ();

    gpio_ctrl #(.WIDTH(W), .OUT_RESET(OUT_RST)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Model of the register map rules for writes.
    function automatic void apply(input logic [3:0] a, input logic [31:0] w);
        logic [7:0] v;
        v = w[7:0];
        case (a)
            4'd0:    m_out = v;
            4'd1:    m_dir = v;
            4'd3:    m_out = m_out | v;
            4'd4:    m_out = m_out & ~v;
            4'd5:    m_out = m_out ^ v;
            default: m_out = m_out;
        endcase
    endfunction

    // Must be called at a negedge; returns one cycle after the response handshake.
    task automatic do_xfer(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata);
        int n;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        chk("req_ready_idle", 32'(bus.req_ready), 32'h1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 16) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rsp_latency", 32'(n), 32'h0);
        rdata = bus.rsp_rdata;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic rd_reg(input logic [3:0] addr, output logic [31:0] rdata);
        @(negedge clk);
        do_xfer(1'b0, addr, 32'h0, rdata);
    endtask

    task automatic wr_reg(input logic [3:0] addr, input logic [31:0] wdata);
        logic [31:0] r;
        @(negedge clk);
        do_xfer(1'b1, addr, wdata, r);
        chk("wr_rdata_zero", r, 32'h0);
    endtask

    // Change the pins at a negedge, then start a transfer accepted k+1 edges later.
    task automatic xfer_after_pin(input logic [7:0] val, input int k, input logic we,
                                  input logic [3:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] rdata);
        @(negedge clk);
        gpio_in = val;
        repeat (k) @(negedge clk);
        do_xfer(we, addr, wdata, rdata);
    endtask

    task automatic settle_pins(input logic [7:0] val);
        @(negedge clk);
        gpio_in = val;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [7:0] nv;
        logic [3:0] a;
        logic [31:0] w;
        int ops[5];
        ops = '{0, 1, 3, 4, 5};

        gpio_in       = 8'h00;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 4'h0;
        bus.req_wdata = 32'h0;
        bus.rsp_ready = 1'b0;
        m_out = OUT_RST[7:0];
        m_dir = 8'h00;
        m_pin = 8'h00;

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_gpio_out", 32'(gpio_out), OUT_RST);
        chk("rst_gpio_oe", 32'(gpio_oe), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Read DATA_OUT by hand: latency and stability while rsp_ready is low
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 4'd0;
        @(posedge clk); #1;
        chk("lat_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("lat_req_ready", 32'(bus.req_ready), 32'h0);
        chk("lat_rdata", bus.rsp_rdata, OUT_RST);
        bus.req_addr = 4'd1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'h1);
            chk("hold_rdata", bus.rsp_rdata, OUT_RST);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("done_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("done_req_ready", 32'(bus.req_ready), 32'h1);
        rd_reg(4'd1, rd);
        chk("rd_dir_rst", rd, 32'h0);
        chk("oe_rst", 32'(gpio_oe), 32'h0);

        // Atomic output writes
        wr_reg(4'd0, 32'h0000_00A5); apply(4'd0, 32'h0000_00A5);
        chk("out_write", 32'(gpio_out), 32'h0000_00A5);
        wr_reg(4'd3, 32'h0000_000F); apply(4'd3, 32'h0000_000F);
        chk("out_set", 32'(gpio_out), 32'h0000_00AF);
        wr_reg(4'd4, 32'h0000_0080); apply(4'd4, 32'h0000_0080);
        chk("out_clr", 32'(gpio_out), 32'h0000_002F);
        wr_reg(4'd5, 32'h0000_0003); apply(4'd5, 32'h0000_0003);
        chk("out_tgl", 32'(gpio_out), 32'h0000_002C);
        rd_reg(4'd3, rd);
        chk("rd_set_zero", rd, 32'h0);

        // Input synchroniser: visible from the 2nd clock after the change
        xfer_after_pin(8'h11, 1, 1'b0, 4'd2, 32'h0, rd);
        chk("din_early", rd, 32'h0);
        settle_pins(8'h00);
        xfer_after_pin(8'h11, 2, 1'b0, 4'd2, 32'h0, rd);
        chk("din_ready", rd, 32'h0000_0011);
        m_pin = 8'h11;
        for (int i = 0; i < 6; i++) begin
            nv = 8'($urandom);
            if (nv == m_pin) nv = ~nv;
            xfer_after_pin(nv, (i % 2) + 1, 1'b0, 4'd2, 32'h0, rd);
            chk("din_rand", rd, ((i % 2) == 1) ? {24'h0, nv} : {24'h0, m_pin});
            m_pin = nv;
        end

        // Edge interrupts
        settle_pins(8'h00);
        wr_reg(4'd6, 32'h0000_0001);
        wr_reg(4'd7, 32'h0000_0002);
        rd_reg(4'd8, rd);
        chk("stat_clean", rd, 32'h0);
        settle_pins(8'h01);
        settle_pins(8'h00);
        settle_pins(8'h02);
        settle_pins(8'h00);
        rd_reg(4'd8, rd);
        chk("stat_both", rd, 32'h0000_0003);
        chk("irq_both", 32'(irq), 32'h1);
        wr_reg(4'd8, 32'h0000_0001);
        rd_reg(4'd8, rd);
        chk("stat_w1c0", rd, 32'h0000_0002);
        chk("irq_bit1", 32'(irq), 32'h1);
        wr_reg(4'd7, 32'h0000_0000);
        chk("irq_masked", 32'(irq), 32'h0);
        rd_reg(4'd8, rd);
        chk("stat_kept", rd, 32'h0000_0002);
        wr_reg(4'd7, 32'h0000_0002);
        chk("irq_unmasked", 32'(irq), 32'h1);
        wr_reg(4'd8, 32'h0000_0002);
        rd_reg(4'd8, rd);
        chk("stat_w1c1", rd, 32'h0);
        chk("irq_clear", 32'(irq), 32'h0);

        // W1C coinciding with a new rising edge: the set wins
        settle_pins(8'h01);
        settle_pins(8'h00);
        rd_reg(4'd8, rd);
        chk("stat_pre", rd, 32'h0000_0001);
        xfer_after_pin(8'h01, 2, 1'b1, 4'd8, 32'h0000_0001, rd);
        rd_reg(4'd8, rd);
        chk("stat_set_wins", rd, 32'h0000_0001);
        wr_reg(4'd8, 32'h0000_0001);
        rd_reg(4'd8, rd);
        chk("stat_plain_w1c", rd, 32'h0);
        settle_pins(8'h00);

        // Random register traffic
        for (int i = 0; i < 16; i++) begin
            a = 4'(ops[$urandom_range(0, 4)]);
            w = $urandom;
            wr_reg(a, w);
            apply(a, w);
            chk("rand_out", 32'(gpio_out), {24'h0, m_out});
            chk("rand_oe", 32'(gpio_oe), {24'h0, m_dir});
        end
        rd_reg(4'd0, rd);
        chk("rand_rd_out", rd, {24'h0, m_out});
        rd_reg(4'd1, rd);
        chk("rand_rd_dir", rd, {24'h0, m_dir});
        for (int i = 0; i < 3; i++) begin
            a = 4'($urandom_range(9, 15));
            wr_reg(a, $urandom);
            chk("unmapped_wr", 32'(gpio_out), {24'h0, m_out});
            rd_reg(a, rd);
            chk("unmapped_rd", rd, 32'h0);
        end

        // Reset in the middle of a response
        wr_reg(4'd0, 32'h0000_00FF);
        wr_reg(4'd1, 32'h0000_00FF);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 4'd0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("mid_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("mid_rdata", bus.rsp_rdata, 32'h0000_00FF);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("arst_req_ready", 32'(bus.req_ready), 32'h1);
        chk("arst_gpio_out", 32'(gpio_out), OUT_RST);
        chk("arst_gpio_oe", 32'(gpio_oe), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_reg(4'd0, rd);
        chk("post_rst_out", rd, OUT_RST);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
